uart_rx: RTL and testbench

- Serial receive datapath of the 16550-style UART core.
- Oversamples srx_pad_i at 16 samples per bit, using the enable tick from the register block's baud divisor.
- Deframes each character per lcr and pushes data plus error flags into a 16-entry receive FIFO.
- Exposes FIFO status and timeout/break counters to the register block for the LSR and interrupt logic.

---
 rtl/uart_rx_pkg.sv | 32 +++
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 73 +++++++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: LCR bit positions, FIFO geometry,
// receiver state encoding and frame-length helper.
package uart_rx_pkg;

    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_COUNTER_W = 5;
    localparam int FIFO_REC_WIDTH = 10;
    localparam int FIFO_PTR_W     = 4;

    localparam int LCR_WLS_LO = 0;
    localparam int LCR_WLS_HI = 1;
    localparam int LCR_STB    = 2;
    localparam int LCR_PEN    = 3;
    localparam int LCR_EPS    = 4;
    localparam int LCR_SP     = 5;

    typedef enum logic [2:0] {
        SR_IDLE   = 3'd0,
        SR_START  = 3'd1,
        SR_DATA   = 3'd2,
        SR_PARITY = 3'd3,
        SR_STOP   = 3'd4,
        SR_PUSH   = 3'd5
    } rx_state_t;

    // Bits per character: start + word + optional parity + one or two stops.
    function automatic logic [3:0] frame_bits(input logic [7:0] lcr);
        return 4'd7 + {2'b00, lcr[LCR_WLS_HI:LCR_WLS_LO]}
                    + {3'b000, lcr[LCR_PEN]} + {3'b000, lcr[LCR_STB]};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Register-block side of the receiver: line control, FIFO handshake and status.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [7:0]                lcr;
    logic                      enable;
    logic                      rf_pop;
    logic                      rda_int;
    logic                      rx_reset;
    logic                      rx_lsr_mask;
    logic [5:0]                counter_t;
    logic [3:0]                counter_b;
    logic [FIFO_COUNTER_W-1:0] rf_count;
    logic [FIFO_REC_WIDTH-1:0] rf_data_out;
    logic                      rf_error_bit;
    logic                      rf_overrun;

    modport master (
        output lcr, enable, rf_pop, rda_int, rx_reset, rx_lsr_mask,
        input  counter_t, counter_b, rf_count, rf_data_out, rf_error_bit, rf_overrun
    );

    modport slave (
        input  lcr, enable, rf_pop, rda_int, rx_reset, rx_lsr_mask,
        output counter_t, counter_b, rf_count, rf_data_out, rf_error_bit, rf_overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// 16-entry show-ahead receive FIFO with sticky overrun and a running count of
// entries carrying a parity or framing error.
module uart_rx_fifo
    import uart_rx_pkg::*;
(
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      push,
    input  logic [FIFO_REC_WIDTH-1:0] push_rec,
    input  logic                      pop,
    input  logic                      flush,
    input  logic                      overrun_clr,
    output logic [FIFO_COUNTER_W-1:0] count,
    output logic [FIFO_REC_WIDTH-1:0] head,
    output logic                      error_bit,
    output logic                      overrun
);

    logic [FIFO_REC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]     wr_ptr;
    logic [FIFO_PTR_W-1:0]     rd_ptr;
    logic [FIFO_COUNTER_W-1:0] err_cnt;
    logic                      full;
    logic                      empty;
    logic                      do_push;
    logic                      do_pop;
    logic                      push_err;
    logic                      pop_err;

    assign full      = (count == FIFO_COUNTER_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign push_err  = do_push && (push_rec[1] || push_rec[0]);
    assign pop_err   = do_pop && (mem[rd_ptr][1] || mem[rd_ptr][0]);
    assign head      = empty ? '0 : mem[rd_ptr];
    assign error_bit = (err_cnt != '0);

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                err_cnt <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count   <= count + FIFO_COUNTER_W'(do_push) - FIFO_COUNTER_W'(do_pop);
                err_cnt <= err_cnt + FIFO_COUNTER_W'(push_err) - FIFO_COUNTER_W'(pop_err);
            end
            // A dropped record must stay visible even if the LSR is read in the same cycle.
            if (push && full)
                overrun <= 1'b1;
            else if (overrun_clr || flush)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer feeding the receive FIFO, plus the
// break and character-timeout counters used by the LSR and interrupt logic.
module uart_rx
    import uart_rx_pkg::*;
(
    input  logic     clk,
    input  logic     wb_rst_i,
    input  logic     srx_pad_i,
    uart_rx_if.slave bus
);

    logic [1:0]                srx_sync;
    logic                      srx;
    rx_state_t                 state;
    logic [3:0]                tick_cnt;
    logic [2:0]                bit_idx;
    logic [2:0]                last_bit;
    logic [7:0]                rx_data;
    logic                      pe;
    logic                      par_exp;
    logic                      rf_push;
    logic [FIFO_REC_WIDTH-1:0] rf_push_rec;
    logic [3:0]                frame_len;
    logic [3:0]                b_sub;
    logic [3:0]                t_sub;
    logic [3:0]                counter_b;
    logic [5:0]                counter_t;
    logic                      t_reload;
    logic                      unused_lcr;

    assign srx        = srx_sync[1];
    assign last_bit   = 3'd4 + {1'b0, bus.lcr[LCR_WLS_HI:LCR_WLS_LO]};
    assign par_exp    = bus.lcr[LCR_SP] ? ~bus.lcr[LCR_EPS]
                                        : ((^rx_data) ^ ~bus.lcr[LCR_EPS]);
    assign frame_len  = frame_bits(bus.lcr);
    assign t_reload   = (bus.rf_count == '0) || rf_push || bus.rf_pop || bus.rda_int;
    assign unused_lcr = ^bus.lcr[7:6];

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)
            srx_sync <= 2'b11;
        else
            srx_sync <= {srx_sync[0], srx_pad_i};
    end

    // Bits are written at their own index so short words land right-aligned.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= SR_IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            rx_data     <= '0;
            pe          <= 1'b0;
            rf_push     <= 1'b0;
            rf_push_rec <= '0;
        end else begin
            rf_push <= 1'b0;
            case (state)
                SR_IDLE: begin
                    if (bus.enable && !srx) begin
                        state    <= SR_START;
                        tick_cnt <= '0;
                    end
                end
                SR_START: begin
                    if (bus.enable) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= '0;
                            if (!srx) begin
                                state   <= SR_DATA;
                                bit_idx <= '0;
                                rx_data <= '0;
                                pe      <= 1'b0;
                            end else begin
                                state <= SR_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                SR_DATA: begin
                    if (bus.enable) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt         <= '0;
                            rx_data[bit_idx] <= srx;
                            bit_idx          <= bit_idx + 3'd1;
                            if (bit_idx == last_bit)
                                state <= bus.lcr[LCR_PEN] ? SR_PARITY : SR_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                SR_PARITY: begin
                    if (bus.enable) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            pe       <= (srx != par_exp);
                            state    <= SR_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                SR_STOP: begin
                    if (bus.enable) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt    <= '0;
                            rf_push     <= 1'b1;
                            rf_push_rec <= {rx_data, pe, ~srx};
                            state       <= SR_PUSH;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                SR_PUSH: begin
                    state <= SR_IDLE;
                end
                default: begin
                    state <= SR_IDLE;
                end
            endcase
        end
    end

    // Break counter: bit-time phase restarts whenever the line returns high.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            counter_b <= 4'hF;
            b_sub     <= '0;
        end else if (srx) begin
            counter_b <= frame_len - 4'd1;
            b_sub     <= '0;
        end else if (bus.enable) begin
            if (b_sub == 4'd15) begin
                b_sub <= '0;
                if (counter_b != '0)
                    counter_b <= counter_b - 4'd1;
            end else begin
                b_sub <= b_sub + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            counter_t <= 6'h3F;
            t_sub     <= '0;
        end else if (t_reload) begin
            counter_t <= {frame_len, 2'b00} - 6'd1;
            t_sub     <= '0;
        end else if (bus.enable) begin
            if (t_sub == 4'd15) begin
                t_sub <= '0;
                if (counter_t != '0)
                    counter_t <= counter_t - 6'd1;
            end else begin
                t_sub <= t_sub + 4'd1;
            end
        end
    end

    assign bus.counter_b = counter_b;
    assign bus.counter_t = counter_t;

    uart_rx_fifo u_fifo (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .push        (rf_push),
        .push_rec    (rf_push_rec),
        .pop         (bus.rf_pop),
        .flush       (bus.rx_reset),
        .overrun_clr (bus.rx_lsr_mask),
        .count       (bus.rf_count),
        .head        (bus.rf_data_out),
        .error_bit   (bus.rf_error_bit),
        .overrun     (bus.rf_overrun)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: serial frames are built bit by bit and the FIFO
// contents are predicted with a queue of expected records.
module tb_uart_rx;

    logic clk       = 1'b0;
    logic wb_rst_i  = 1'b1;
    logic srx_pad_i = 1'b1;

    uart_rx_if u_if ();

    uart_rx dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .srx_pad_i (srx_pad_i),
        .bus       (u_if)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [9:0] q[$];
    bit         ovr_m  = 1'b0;

    always #5 clk = ~clk;

    // Baud tick: one clk-wide pulse every fourth clock.
    initial begin
        int div;
        div = 0;
        u_if.enable = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            u_if.enable = (div == 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!u_if.enable) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        srx_pad_i = b;
        wait_ticks(16);
    endtask

    function automatic bit model_err();
        foreach (q[i])
            if (q[i][1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int frame_len(input logic [7:0] l);
        return 1 + (5 + int'(l[1:0])) + int'(l[3]) + (l[2] ? 2 : 1);
    endfunction

    task automatic send_frame(input logic [7:0] lcr_v, input logic [7:0] d,
                              input bit bad_par, input bit bad_stop);
        int         n;
        int         ones;
        logic [7:0] dm;
        logic       pc;
        logic       pbit;
        logic       pe_exp;
        u_if.lcr = lcr_v;
        n  = 5 + int'(lcr_v[1:0]);
        dm = d & 8'((1 << n) - 1);
        ones = $countones(dm);
        if (lcr_v[5])      pc = ~lcr_v[4];
        else if (lcr_v[4]) pc = (ones % 2) == 1;
        else               pc = (ones % 2) == 0;
        pbit   = pc ^ bad_par;
        pe_exp = lcr_v[3] && bad_par;
        wait_ticks(1);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(dm[i]);
        if (lcr_v[3]) send_bit(pbit);
        send_bit(~bad_stop);
        if (lcr_v[2]) send_bit(1'b1);
        send_bit(1'b1);
        if (q.size() == 16) ovr_m = 1'b1;
        else q.push_back({dm, pe_exp, bad_stop});
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_count"}, 32'(u_if.rf_count), 32'(q.size()));
        check({tag, "_err"},   32'(u_if.rf_error_bit), 32'(model_err()));
        check({tag, "_ovr"},   32'(u_if.rf_overrun), 32'(ovr_m));
        check({tag, "_head"},  32'(u_if.rf_data_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    endtask

    task automatic pulse_pop();
        @(negedge clk); u_if.rf_pop = 1'b1;
        @(negedge clk); u_if.rf_pop = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_pre"}, 32'(u_if.rf_data_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        pulse_pop();
        if (q.size() > 0) void'(q.pop_front());
        check_fifo(tag);
    endtask

    initial begin
        logic [7:0] lcr_r;
        logic [7:0] lcr_list [5];
        int         k;
        int         f;
        lcr_list = '{8'h00, 8'h03, 8'h0F, 8'h1B, 8'h04};
        u_if.lcr         = 8'h03;
        u_if.rf_pop      = 1'b0;
        u_if.rda_int     = 1'b0;
        u_if.rx_reset    = 1'b0;
        u_if.rx_lsr_mask = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_count", 32'(u_if.rf_count), 32'd0);
        check("rst_data",  32'(u_if.rf_data_out), 32'd0);
        check("rst_ovr",   32'(u_if.rf_overrun), 32'd0);
        check("rst_err",   32'(u_if.rf_error_bit), 32'd0);
        check("rst_cb",    32'(u_if.counter_b), 32'hF);
        check("rst_ct",    32'(u_if.counter_t), 32'h3F);
        wb_rst_i = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(8'h03, 8'hA5, 1'b0, 1'b0);
        check("a5_rec", 32'(u_if.rf_data_out), 32'(10'b1010010100));
        check_fifo("a5");
        pop_check("a5_pop");

        send_frame(8'h1B, 8'h01, 1'b1, 1'b0);
        check("pe_flag", 32'(u_if.rf_data_out[1]), 32'd1);
        check_fifo("pe");
        pop_check("pe_pop");

        send_frame(8'h00, 8'h1F, 1'b0, 1'b1);
        check("fe_rec", 32'(u_if.rf_data_out), 32'(10'b0001111101));
        check_fifo("fe");
        pop_check("fe_pop");

        pulse_pop();
        check_fifo("empty_pop");

        for (int i = 0; i < 24; i++) begin
            lcr_r = 8'($urandom_range(0, 63));
            send_frame(lcr_r, 8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            check_fifo("rnd");
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++)
                if (q.size() > 0) pop_check("rnd_pop");
        end
        while (q.size() > 0) pop_check("rnd_drain");

        for (int i = 0; i < 17; i++)
            send_frame(8'h03, 8'($urandom), 1'b0, 1'b0);
        check_fifo("ovr");
        @(negedge clk); u_if.rx_lsr_mask = 1'b1;
        @(negedge clk); u_if.rx_lsr_mask = 1'b0;
        ovr_m = 1'b0;
        check_fifo("ovr_clr");
        while (q.size() > 0) pop_check("ovr_drain");

        foreach (lcr_list[i]) begin
            u_if.lcr = lcr_list[i];
            repeat (2) @(negedge clk);
            f = frame_len(lcr_list[i]);
            check("reload_ct", 32'(u_if.counter_t), 32'(4 * f - 1));
            check("reload_cb", 32'(u_if.counter_b), 32'(f - 1));
        end

        send_frame(8'h03, 8'($urandom), 1'b0, 1'b0);
        check("to_start", 32'(u_if.counter_t >= 6'd37 && u_if.counter_t <= 6'd39), 32'd1);
        wait_ticks(16 * 29);
        check("to_mid", 32'(u_if.counter_t != 6'd0), 32'd1);
        wait_ticks(16 * 10);
        check("to_zero", 32'(u_if.counter_t), 32'd0);
        @(negedge clk); u_if.rda_int = 1'b1;
        @(negedge clk);
        check("rda_reload", 32'(u_if.counter_t), 32'd39);
        u_if.rda_int = 1'b0;
        wait_ticks(48);
        check("rda_dec", 32'(u_if.counter_t >= 6'd35 && u_if.counter_t <= 6'd38), 32'd1);
        pop_check("to_pop");
        check("to_reload", 32'(u_if.counter_t), 32'd39);

        wait_ticks(1);
        srx_pad_i = 1'b0;
        wait_ticks(16 * 4);
        check("brk_mid", 32'(u_if.counter_b >= 4'd4 && u_if.counter_b <= 4'd6), 32'd1);
        wait_ticks(16 * 8);
        check("brk_zero", 32'(u_if.counter_b), 32'd0);
        check("brk_fe", 32'(u_if.rf_error_bit), 32'd1);
        srx_pad_i = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_reload", 32'(u_if.counter_b), 32'd9);
        wait_ticks(16 * 12);
        @(negedge clk); u_if.rx_reset = 1'b1;
        @(negedge clk); u_if.rx_reset = 1'b0;
        q.delete();
        ovr_m = 1'b0;
        check_fifo("flush");

        send_frame(8'h03, 8'($urandom), 1'b0, 1'b0);
        check_fifo("post_flush");
        pop_check("post_flush_pop");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
